// File: rtl/seg7_pkg.sv
// Shared segment codes (active-high, SEG[6]=a .. SEG[0]=g) and the polarity helper
// used by the 7-segment display blocks.
package seg7_pkg;
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Common-anode boards drive everything active-low.
  function automatic logic [6:0] apply_pol(input logic [6:0] seg, input bit ca);
    return ca ? ~seg : seg;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high a..g pattern; non-decimal codes render as blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIG-digit 7-segment driver: double-buffered digits, programmable
// scan rate, leading-zero blanking, blink and selectable output polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIG         = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] D,
  input  logic              LD,
  input  logic              BLANK_LZ,
  input  logic              BLINK,
  output logic [6:0]        SEG,
  output logic [NDIG-1:0]   AN,
  output logic              FRAME
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW = $clog2(2 * BLINK_FRAMES);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NDIG - 1);
  localparam logic [FW-1:0] F_LAST = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0] F_HALF = FW'(BLINK_FRAMES);

  logic [PW-1:0]     pcnt;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     fcnt;
  logic [4*NDIG-1:0] shadow, active;
  logic [3:0]        cur;
  logic [6:0]        pat;
  logic [NDIG-1:0]   an_sel;
  logic              zero_hi, blank_lz, blink_off, slot_end, frame_end;

  assign slot_end  = (pcnt == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);
  assign blink_off = BLINK && (fcnt >= F_HALF);

  // Walk from the most significant digit down so zero_hi means "this digit and all above are 0".
  always_comb begin
    cur      = 4'd0;
    blank_lz = 1'b0;
    an_sel   = '0;
    zero_hi  = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_hi = zero_hi && (active[4*k +: 4] == 4'd0);
      if (IW'(k) == idx) begin
        cur       = active[4*k +: 4];
        blank_lz  = BLANK_LZ && (k != 0) && zero_hi;
        an_sel[k] = 1'b1;
      end
    end
  end

  seg7_decode u_dec (.bcd(cur), .seg(pat));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt   <= '0;
      idx    <= '0;
      fcnt   <= '0;
      shadow <= '0;
      active <= '0;
      SEG    <= apply_pol(SEG_OFF, COMMON_ANODE);
      AN     <= {NDIG{COMMON_ANODE}};
      FRAME  <= 1'b0;
    end else begin
      if (LD) shadow <= D;
      FRAME <= frame_end;
      // pcnt==0 is a dead cycle with no enable, hiding segment transitions between digits.
      AN    <= (((pcnt == '0) || blink_off) ? '0 : an_sel) ^ {NDIG{COMMON_ANODE}};
      SEG   <= apply_pol((blank_lz || blink_off) ? SEG_OFF : pat, COMMON_ANODE);
      if (slot_end) begin
        pcnt <= '0;
        if (idx == I_LAST) begin
          idx    <= '0;
          active <= shadow;
          fcnt   <= (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: NDIG=2, SCAN_DIV=4, BLINK_FRAMES=2, one instance per polarity.
module tb_seg7_scan_driver;
  logic       CLK = 1'b0;
  logic       RST, LD, BLANK_LZ, BLINK;
  logic [7:0] D;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic       frame0, frame1;

  int checks, failures, nframes, phase, first;
  logic [1:0] an_s0 [1:8];
  logic [1:0] an_s1 [1:8];
  logic [6:0] seg_s0 [1:8];
  logic [6:0] seg_s1 [1:8];
  logic       fr_s [1:8];
  logic [1:0] an_exp [1:8];

  always #5 CLK = ~CLK;

  seg7_scan_driver #(.NDIG(2), .SCAN_DIV(4), .BLINK_FRAMES(2), .COMMON_ANODE(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .D(D), .LD(LD), .BLANK_LZ(BLANK_LZ), .BLINK(BLINK),
    .SEG(seg0), .AN(an0), .FRAME(frame0));

  seg7_scan_driver #(.NDIG(2), .SCAN_DIV(4), .BLINK_FRAMES(2), .COMMON_ANODE(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .D(D), .LD(LD), .BLANK_LZ(BLANK_LZ), .BLINK(BLINK),
    .SEG(seg1), .AN(an1), .FRAME(frame1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the first FRAME pulse; leaves the bench on the negedge showing it.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge CLK);
      seen = frame0;
    end
    chk("frame_timeout", 32'(seen), 32'd1);
    nframes++;
  endtask

  // Sample one full frame (8 cycles), optionally pulsing LD mid-frame.
  task automatic run_frame(input bit do_ld, input logic [7:0] ldv);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      an_s0[k] = an0;  seg_s0[k] = seg0;
      an_s1[k] = an1;  seg_s1[k] = seg1;
      fr_s[k]  = frame0;
      if (do_ld && k == 3) begin D = ldv; LD = 1'b1; end
      if (k == 4) LD = 1'b0;
    end
    nframes++;
    chk("frame_period", 32'(fr_s[8]), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; nframes = 0;
    an_exp[1] = 2'b00; an_exp[2] = 2'b01; an_exp[3] = 2'b01; an_exp[4] = 2'b01;
    an_exp[5] = 2'b00; an_exp[6] = 2'b10; an_exp[7] = 2'b10; an_exp[8] = 2'b10;
    RST = 1'b1; D = 8'h00; LD = 1'b0; BLANK_LZ = 1'b0; BLINK = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_seg_cc",   32'(seg0),   32'h00);
    chk("rst_an_cc",    32'(an0),    32'h0);
    chk("rst_frame_cc", 32'(frame0), 32'h0);
    chk("rst_seg_ca",   32'(seg1),   32'h7f);
    chk("rst_an_ca",    32'(an1),    32'h3);
    chk("rst_frame_ca", 32'(frame1), 32'h0);

    // Scan 93
    RST = 1'b0; D = 8'h93; LD = 1'b1;
    @(negedge CLK);
    LD = 1'b0;
    wait_frame();
    run_frame(1'b0, 8'h00);
    for (int k = 1; k <= 8; k++) chk($sformatf("scan_an_%0d", k), 32'(an_s0[k]), 32'(an_exp[k]));
    chk("scan_frame_mid", 32'(fr_s[4]),   32'd0);
    chk("scan_seg_d0",    32'(seg_s0[2]), 32'(7'b1111001));
    chk("scan_seg_d1",    32'(seg_s0[6]), 32'(7'b1111011));
    chk("scan_an_ca",     32'(an_s1[2]),  32'(2'b10));
    chk("scan_seg_ca",    32'(seg_s1[2]), 32'(7'b0000110));

    // Tear-free update
    run_frame(1'b1, 8'h42);
    chk("tear_d1_before", 32'(seg_s0[6]), 32'(7'b1111011));
    chk("tear_d1_after",  32'(seg_s0[7]), 32'(7'b1111011));
    run_frame(1'b0, 8'h00);
    chk("new_d0", 32'(seg_s0[2]), 32'(7'b1101101));
    chk("new_d1", 32'(seg_s0[6]), 32'(7'b0110011));

    // Leading-zero blanking
    BLANK_LZ = 1'b1;
    run_frame(1'b1, 8'h05);
    run_frame(1'b0, 8'h00);
    chk("lz05_d1_seg", 32'(seg_s0[6]), 32'(7'b0000000));
    chk("lz05_d1_an",  32'(an_s0[6]),  32'(2'b10));
    chk("lz05_d0_seg", 32'(seg_s0[2]), 32'(7'b1011011));
    run_frame(1'b1, 8'h00);
    run_frame(1'b0, 8'h00);
    chk("lz00_d0_seg", 32'(seg_s0[2]), 32'(7'b1111110));
    chk("lz00_d1_seg", 32'(seg_s0[6]), 32'(7'b0000000));

    // Invalid code and common-anode polarity
    BLANK_LZ = 1'b0;
    run_frame(1'b1, 8'hA7);
    run_frame(1'b0, 8'h00);
    chk("ca_d1_seg", 32'(seg_s1[6]), 32'(7'b1111111));
    chk("ca_d0_seg", 32'(seg_s1[2]), 32'(7'b0001111));
    chk("ca_d0_an",  32'(an_s1[2]),  32'(2'b10));
    chk("ca_d1_an",  32'(an_s1[6]),  32'(2'b01));
    chk("cc_d1_inv", 32'(seg_s0[6]), 32'(7'b0000000));

    // Blink: fcnt equals the number of frame boundaries since reset, modulo 4
    BLINK = 1'b1;
    for (int f = 0; f < 4; f++) begin
      phase = nframes % 4;
      run_frame(1'b0, 8'h00);
      chk($sformatf("blink_an0_f%0d", f),  32'(an_s0[3]),  (phase >= 2) ? 32'd0 : 32'(2'b01));
      chk($sformatf("blink_an1_f%0d", f),  32'(an_s0[7]),  (phase >= 2) ? 32'd0 : 32'(2'b10));
      chk($sformatf("blink_seg_f%0d", f), 32'(seg_s0[3]), (phase >= 2) ? 32'd0 : 32'(7'b1110000));
    end
    // Now in an off frame; dropping BLINK brings the next slot back
    chk("blink_phase_off", 32'(nframes % 4), 32'd2);
    repeat (2) @(negedge CLK);
    chk("blink_off_an", 32'(an0), 32'd0);
    @(negedge CLK);
    BLINK = 1'b0;
    repeat (3) @(negedge CLK);
    chk("blink_resume_an", 32'(an0), 32'(2'b10));
    repeat (2) @(negedge CLK);
    chk("blink_resume_frame", 32'(frame0), 32'd1);

    // Asynchronous reset mid-scan
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("mid_rst_seg",   32'(seg0),   32'h00);
    chk("mid_rst_an",    32'(an0),    32'h0);
    chk("mid_rst_frame", 32'(frame0), 32'h0);
    chk("mid_rst_an_ca", 32'(an1),    32'h3);
    @(negedge CLK);
    RST = 1'b0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 2) begin
        chk("restart_an",  32'(an0),  32'(2'b01));
        chk("restart_seg", 32'(seg0), 32'(7'b1111110));
      end
      if (frame0 && first == 0) first = i;
    end
    chk("restart_frame_at", 32'(first), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an NDIG-digit 7-segment display, the multi-digit successor to the single-digit BCD decoder. Accepts packed BCD digits through a load strobe, double-buffers them so a digit update never tears mid-scan, and scans the digits at a programmable rate. Adds selectable common-cathode/common-anode polarity, leading-zero blanking and blink. Sits between the 99→00 down-counter and the board pins.

## Interface
- NDIG, 2: number of digits, 1..8.
- SCAN_DIV, 50000: CLK cycles per digit slot, ≥2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥1.
- COMMON_ANODE, 0: 0 = segments/enables active-high; 1 = all active-low.

- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- D  in  4*NDIG  packed BCD; D[3:0] = digit 0 (least significant).
- LD  in  1  load strobe; D captured into shadow buffer on any CLK edge with LD=1.
- BLANK_LZ  in  1  1 = blank leading zeros.
- BLINK  in  1  1 = display blinks.
- SEG  out  7  segments, SEG[6]=a … SEG[0]=g.
- AN  out  NDIG  digit enables, AN[k] selects digit k.
- FRAME  out  1  one-cycle pulse at end of each full scan.

## Operation
- Segment code (active-high form, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; codes 10–15 = 0000000 (off).
- COMMON_ANODE=1 inverts SEG and AN; "off" then means all ones.
- Buffers: shadow ← D on LD. Active ← shadow at each frame boundary (digit index wraps NDIG-1→0). Display reads active only.
- Prescaler pcnt counts 0..SCAN_DIV-1; at wrap, index idx advances 0→1→…→NDIG-1→0.
- Digit k is blanked (SEG off, AN[k] still enabled) when BLANK_LZ=1, k>0, and active digits k..NDIG-1 are all 0. Digit 0 is never blanked by LZ (value 0 shows "0").
- Blink: frame counter fcnt counts 0..2*BLINK_FRAMES-1 on FRAME. When BLINK=1 and fcnt ≥ BLINK_FRAMES, AN all inactive and SEG off. BLINK=0 forces on; fcnt keeps running.
- Ghost suppression: during pcnt==0 of every slot, AN all inactive (one dead cycle per slot).

## Timing
- Reset values: SEG off, AN all inactive, FRAME=0; pcnt, idx, fcnt = 0; shadow, active = 0.
- SEG, AN, FRAME are registered; they reflect pcnt/idx/active of the previous cycle (1-cycle latency).
- FRAME asserts the cycle after pcnt==SCAN_DIV-1 with idx==NDIG-1; same edge that active ← shadow.
- LD at edge t: shadow valid after t; appears on SEG no earlier than next frame boundary, and within one frame period (NDIG*SCAN_DIV cycles) plus 1.
- LD coincident with frame boundary: active takes the old shadow; new value shown next frame.
- Multiple LD within one frame: last one wins.
- RST mid-scan: all state returns to reset values immediately; scan restarts at idx=0, pcnt=0.
- NDIG=1: idx constant 0, FRAME every SCAN_DIV cycles.

## Structure
- Shared include seg7_pkg.vh: segment code constants SEG_0..SEG_9, SEG_OFF, and a polarity-apply macro/function.
- Sub-module seg7_decode (combinational, 4-bit BCD → 7-bit active-high pattern, invalid → off); one instance fed by the selected digit.
- Top holds prescaler, index, frame/blink counters, shadow/active buffers, LZ logic, output registers.

## Test plan
- Reset: assert RST mid-scan with SCAN_DIV=4, NDIG=2 → SEG=0000000, AN=00, FRAME=0 same cycle; restart at idx 0.
- Scan: D=8'h93, LD pulse, SCAN_DIV=4 → after first frame, AN cycles 00,01,01,01,00,10,10,10; SEG=1111001 with AN=01, 1111011 with AN=10; FRAME every 8 cycles.
- Tear-free: LD D=8'h42 mid-frame → no SEG change until FRAME; next frame shows 0110011/1101101.
- LZ: D=8'h05, BLANK_LZ=1 → digit 1 SEG off, digit 0 1011011; D=8'h00 → digit 0 shows 1111110.
- Invalid/polarity: COMMON_ANODE=1, D=8'hA7 → digit 1 SEG=1111111, digit 0 SEG=0001111, active AN bit =0.
- Blink: BLINK_FRAMES=2, BLINK=1 → AN active 2 frames, all inactive 2 frames, repeating; drop BLINK → display resumes on next slot.
